mul_shiftadd: RTL and testbench
===============================

Name: mul_shiftadd

Overview:
- Sequential unsigned shift-add multiply-accumulate. Computes product = multiplicand * multiplier + addend over DATA_W+2 cycles.
- It is the inverse companion of the team's subtract-shift divider: rebuilds dividend = quotient * divisor + remainder.
- Used for divider self-check and for general low-area multiplication in the datapath.
- Uses the same level-enabled en/done protocol as the divider.

Parameters:
- DATA_W, 32, width of each operand; product is 2*DATA_W bits.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-low. Sampled on the rising clk edge; when 0, the block resets.
- en  input  1  level enable. Rising/held high runs one operation. Low clears the block.
- done  output  1  product valid. Held high while en stays high.
- multiplicand  input  DATA_W  operand A, sampled at load cycle only.
- multiplier  input  DATA_W  operand B, sampled at load cycle only.
- addend  input  DATA_W  operand C, sampled at load cycle only.
- product  output  2*DATA_W  A*B+C, unsigned. Valid when done=1.

Behaviour:
- State:
  - acc: 2*DATA_W+1 bits, {carry, hi[DATA_W], lo[DATA_W]}.
  - mcand_reg: DATA_W bits.
  - pc: counter, $clog2(DATA_W+2)+1 bits.
- Reset (rst=0 at clk edge): pc=0, acc=0, done=0. mcand_reg is don't-care. Reset overrides en.
- en=0 (rst=1): pc=0, acc=0, done=0 on the next edge. This is an abort if mid-operation; no partial result is retained.
- en=1, sequenced by pc:
  - pc=0 (load): mcand_reg<=multiplicand; acc<={1'b0, addend, multiplier}; pc<=1.
  - pc=1..DATA_W (iterate): sum = {1'b0,hi} + (lo[0] ? {1'b0,mcand_reg} : 0). Then acc <= {sum, lo} >> 1, a right shift of DATA_W+1+DATA_W bits with carry into the top. pc<=pc+1.
  - pc=DATA_W+1 (finish): done<=1; pc and acc hold for as long as en=1.
- Addend handling: the initial hi contents shift down DATA_W places, so addend adds at weight 2^0.
- Overflow: impossible, since (2^W-1)^2 + (2^W-1) < 2^(2W). The carry bit is always 0 at finish.
- product = acc[2*DATA_W-1:0], driven continuously. It is meaningful only when done=1 and is 0 after reset or abort.
- Latency: en first sampled high at edge 0 (load). done first seen high after edge DATA_W+1, i.e. DATA_W+2 edges including the load edge.
- Operand changes after the load edge are ignored.
- New operation: en must be low for at least one edge, which returns pc to 0, then high again.
- en glitch low for one cycle mid-run: full abort, then restart from the load cycle.
- No back-pressure. Consumer samples product while done=1.

Test Plan:
- DATA_W=8, A=13, B=11, C=5, en held high -> done rises after the load edge plus 9 edges; product=16'h0094 (148), held stable while en=1.
- DATA_W=8, A=255, B=255, C=255 -> product=16'hFF00. Internal carry bit is 0 throughout the finish state.
- DATA_W=8, A=200, B=0, C=7 -> product=16'h0007. A=0, B=0, C=0 -> product=0, done still asserts with identical latency.
- Abort: start A=13, B=11, C=5; drop en at pc=4 -> next edge done=0, product=0, pc=0. Re-raise en with A=3, B=4, C=1 -> product=13 with full latency.
- Reset mid-op: rst=0 for one edge at pc=5 with en=1 -> done=0, product=0 after that edge. Operation restarts from load once rst=1, en still high.
- Random DATA_W=32 check: 1000 random A, B, C against a 64-bit reference model. Also divide-then-multiply round trip: feed divider quotient/divisor/remainder and require product == original dividend.

Source files
------------

// File: rtl/mul_shiftadd.sv
// Sequential unsigned shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One load cycle, DATA_W shift-add cycles, then done holds while en stays high.
//
//   pc          | meaning
//   0           | idle / load operands on en=1
//   1..DATA_W   | iterate: conditional add of mcand into hi, shift {carry,hi,lo} right
//   DATA_W+1    | finish: done=1, acc held while en=1
module mul_shiftadd #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W-1:0]   multiplicand,
  input  logic [DATA_W-1:0]   multiplier,
  input  logic [DATA_W-1:0]   addend,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int PC_W = $clog2(DATA_W + 2) + 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DATA_W);
  localparam logic [PC_W-1:0] PC_FIN  = PC_W'(DATA_W + 1);

  logic [2*DATA_W:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   sum;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    pc_d    = pc_q;
    done_d  = done_q;
    sum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
              (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
    if (!en) begin
      acc_d  = '0;
      pc_d   = '0;
      done_d = 1'b0;
    end else if (pc_q == '0) begin
      mcand_d = multiplicand;
      acc_d   = {1'b0, addend, multiplier};
      pc_d    = PC_W'(1);
    end else if (pc_q <= PC_LAST) begin
      // Carry enters the top bit; the consumed multiplier bit falls off the bottom.
      acc_d = {sum, acc_q[DATA_W-1:0]} >> 1;
      pc_d  = pc_q + PC_W'(1);
    end else begin
      pc_d   = PC_FIN;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q[2*DATA_W-1:0];

endmodule

// File: tb/tb_mul_shiftadd.sv
// Directed and reference-model checks of mul_shiftadd at DATA_W=8 and DATA_W=32.
module tb_mul_shiftadd;

  logic        clk = 1'b0;
  logic        rst8 = 1'b0, en8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
  logic        done8;
  logic [15:0] p8;
  logic        rst32 = 1'b0, en32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, c32 = '0;
  logic        done32;
  logic [63:0] p32;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mul_shiftadd #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .multiplicand(a8), .multiplier(b8),
    .addend(c8), .done(done8), .product(p8)
  );

  mul_shiftadd #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst32), .en(en32), .multiplicand(a32), .multiplier(b32),
    .addend(c32), .done(done32), .product(p32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns edges from the load edge (counted as 1) up to the first edge after which done is high.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, output int lat);
    en8 = 1'b0;
    step();
    a8 = a; b8 = b; c8 = c; en8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, output int lat);
    en32 = 1'b0;
    step();
    a32 = a; b32 = b; c32 = c; en32 = 1'b1;
    lat = 0;
    while (!done32 && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b0; rst32 = 1'b0; en8 = 1'b1; en32 = 1'b1;
    a8 = 8'd13; b8 = 8'd11; c8 = 8'd5;
    repeat (3) step();
    total++;
    if (done8 !== 1'b0 || p8 !== 16'h0000) begin
      bad++;
      $display("FAIL reset8: done=%b product=%h required done=0 product=0000", done8, p8);
    end
    total++;
    if (done32 !== 1'b0 || p32 !== 64'h0) begin
      bad++;
      $display("FAIL reset32: done=%b product=%h required done=0 product=0", done32, p32);
    end
    en8 = 1'b0; en32 = 1'b0;
    rst8 = 1'b1; rst32 = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] first;
    run8(8'd13, 8'd11, 8'd5, lat);
    total++;
    if (lat !== 10) begin
      bad++;
      $display("FAIL basic_latency: edges=%0d required=10", lat);
    end
    total++;
    if (p8 !== 16'h0094) begin
      bad++;
      $display("FAIL basic_product: got=%h required=0094", p8);
    end
    first = p8;
    a8 = 8'd99; b8 = 8'd77; c8 = 8'd1;
    repeat (4) step();
    total++;
    if (done8 !== 1'b1 || p8 !== 16'h0094 || first !== 16'h0094) begin
      bad++;
      $display("FAIL basic_hold: done=%b product=%h required done=1 product=0094", done8, p8);
    end
    en8 = 1'b0;
    step();
    total++;
    if (done8 !== 1'b0 || p8 !== 16'h0000) begin
      bad++;
      $display("FAIL basic_clear: done=%b product=%h required done=0 product=0000", done8, p8);
    end
  endtask

  task automatic test_max();
    int lat;
    int carry_bad;
    run8(8'hFF, 8'hFF, 8'hFF, lat);
    total++;
    if (lat !== 10 || p8 !== 16'hFF00) begin
      bad++;
      $display("FAIL max_product: edges=%0d product=%h required edges=10 product=ff00", lat, p8);
    end
    carry_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (dut8.acc_q[16] !== 1'b0 || done8 !== 1'b1) carry_bad++;
      step();
    end
    total++;
    if (carry_bad != 0) begin
      bad++;
      $display("FAIL max_carry: cycles_with_carry_or_no_done=%0d required=0", carry_bad);
    end
  endtask

  task automatic test_zero();
    int lat;
    run8(8'd200, 8'd0, 8'd7, lat);
    total++;
    if (lat !== 10 || p8 !== 16'h0007) begin
      bad++;
      $display("FAIL zero_mult: edges=%0d product=%h required edges=10 product=0007", lat, p8);
    end
    run8(8'd0, 8'd0, 8'd0, lat);
    total++;
    if (lat !== 10 || p8 !== 16'h0000 || done8 !== 1'b1) begin
      bad++;
      $display("FAIL all_zero: edges=%0d done=%b product=%h required edges=10 done=1 product=0000", lat, done8, p8);
    end
  endtask

  task automatic test_abort();
    int lat;
    en8 = 1'b0;
    step();
    a8 = 8'd13; b8 = 8'd11; c8 = 8'd5; en8 = 1'b1;
    repeat (4) step();
    total++;
    if (dut8.pc_q !== 5'd4) begin
      bad++;
      $display("FAIL abort_pc_before: pc=%0d required=4", dut8.pc_q);
    end
    en8 = 1'b0;
    step();
    total++;
    if (done8 !== 1'b0 || p8 !== 16'h0000 || dut8.pc_q !== 5'd0) begin
      bad++;
      $display("FAIL abort_clear: done=%b product=%h pc=%0d required 0/0000/0", done8, p8, dut8.pc_q);
    end
    run8(8'd3, 8'd4, 8'd1, lat);
    total++;
    if (lat !== 10 || p8 !== 16'd13) begin
      bad++;
      $display("FAIL abort_restart: edges=%0d product=%0d required edges=10 product=13", lat, p8);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    en8 = 1'b0;
    step();
    a8 = 8'd13; b8 = 8'd11; c8 = 8'd5; en8 = 1'b1;
    repeat (5) step();
    rst8 = 1'b0;
    step();
    total++;
    if (done8 !== 1'b0 || p8 !== 16'h0000) begin
      bad++;
      $display("FAIL rst_midop_clear: done=%b product=%h required done=0 product=0000", done8, p8);
    end
    rst8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 20) begin
      step();
      lat++;
    end
    total++;
    if (lat !== 10 || p8 !== 16'h0094) begin
      bad++;
      $display("FAIL rst_midop_restart: edges=%0d product=%h required edges=10 product=0094", lat, p8);
    end
  endtask

  task automatic test_random32();
    int lat;
    int nbad_p, nbad_l;
    logic [31:0] a, b, c;
    logic [63:0] expv;
    nbad_p = 0; nbad_l = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom(); b = $urandom(); c = $urandom();
      if (i == 0) begin a = '1; b = '1; c = '1; end
      expv = 64'(a) * 64'(b) + 64'(c);
      run32(a, b, c, lat);
      total++;
      if (p32 !== expv) begin
        bad++;
        nbad_p++;
        if (nbad_p <= 5)
          $display("FAIL rand32_product: a=%h b=%h c=%h got=%h required=%h", a, b, c, p32, expv);
      end
      total++;
      if (lat !== 34) begin
        bad++;
        nbad_l++;
        if (nbad_l <= 5) $display("FAIL rand32_latency: edges=%0d required=34", lat);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [31:0] dvd [6];
    logic [31:0] dvs [6];
    logic [31:0] q, r;
    int lat;
    dvd[0] = 32'd1000;       dvs[0] = 32'd7;
    dvd[1] = 32'hFFFF_FFFF;  dvs[1] = 32'd1;
    dvd[2] = 32'hFFFF_FFFF;  dvs[2] = 32'hFFFF_FFFF;
    dvd[3] = 32'd12345678;   dvs[3] = 32'd1000;
    dvd[4] = 32'd0;          dvs[4] = 32'd5;
    dvd[5] = 32'hDEAD_BEEF;  dvs[5] = 32'h0001_2345;
    for (int i = 0; i < 6; i++) begin
      q = dvd[i] / dvs[i];
      r = dvd[i] % dvs[i];
      run32(q, dvs[i], r, lat);
      total++;
      if (p32 !== {32'h0, dvd[i]} || lat !== 34) begin
        bad++;
        $display("FAIL roundtrip_%0d: product=%h edges=%0d required product=%h edges=34", i, p32, lat, {32'h0, dvd[i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_abort();
    test_reset_midop();
    test_random32();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
